// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix widths, FSM
// state encoding and small combinational helpers used by the scanner.
package keypad_pkg;

    localparam int ROW_W = 4;
    localparam int COL_W = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    // Index of the lowest-numbered column that is pulled low (0 if none).
    function automatic logic [1:0] lowest_low_col(input logic [COL_W-1:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = COL_W - 1; i >= 0; i--) begin
            if (!c[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Active-low one-hot row drive for the selected row.
    function automatic logic [ROW_W-1:0] row_drive(input logic [1:0] idx);
        return 4'b1111 - (4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan-rate divider: emits a one-cycle tick every SCAN_DIV clk cycles.
import keypad_pkg::*;

module keypad_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] div_cnt;

    // Free-running divider, wraps to 0 the cycle after reaching SCAN_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, debounces
// a detected press and its release on the scan tick, and reports the
// accepted key as row_idx*4 + col_idx.
import keypad_pkg::*;

module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [3:0]       key_code,
    output logic             key_valid,
    output logic             key_pressed
);

    localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
    localparam logic [DW-1:0] DB_ONE  = DW'(1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CNT - 1);
    localparam bit            DB_SINGLE = (DEBOUNCE_CNT == 1);

    logic             tick;
    logic [COL_W-1:0] col_meta_p0;
    logic [COL_W-1:0] col_s;
    scan_state_t      state;
    logic [1:0]       row_idx;
    logic [1:0]       cap_col;
    logic [DW-1:0]    db_cnt;
    logic [1:0]       low_col;
    logic             cap_low;

    keypad_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_p0 <= '1;
            col_s       <= '1;
        end else begin
            col_meta_p0 <= col;
            col_s       <= col_meta_p0;
        end
    end

    assign low_col = lowest_low_col(col_s);
    assign cap_low = ~col_s[cap_col];
    assign row     = row_drive(row_idx);

    // Scan / debounce / hold / release FSM with registered key outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SCAN;
            row_idx     <= 2'd0;
            cap_col     <= 2'd0;
            db_cnt      <= '0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (col_s == '1) begin
                            row_idx <= row_idx + 2'd1;
                        end else begin
                            cap_col <= low_col;
                            if (DB_SINGLE) begin
                                db_cnt      <= DB_MAX;
                                state       <= ST_HELD;
                                key_code    <= {row_idx, low_col};
                                key_valid   <= 1'b1;
                                key_pressed <= 1'b1;
                            end else begin
                                db_cnt <= DB_ONE;
                                state  <= ST_DEBOUNCE;
                            end
                        end
                    end

                    ST_DEBOUNCE: begin
                        if (cap_low) begin
                            if (db_cnt == DB_LAST) begin
                                db_cnt      <= DB_MAX;
                                state       <= ST_HELD;
                                key_code    <= {row_idx, cap_col};
                                key_valid   <= 1'b1;
                                key_pressed <= 1'b1;
                            end else begin
                                db_cnt <= db_cnt + DB_ONE;
                            end
                        end else begin
                            db_cnt  <= '0;
                            state   <= ST_SCAN;
                            row_idx <= row_idx + 2'd1;
                        end
                    end

                    ST_HELD: begin
                        if (!cap_low) begin
                            if (DB_SINGLE) begin
                                db_cnt      <= '0;
                                state       <= ST_SCAN;
                                row_idx     <= row_idx + 2'd1;
                                key_pressed <= 1'b0;
                            end else begin
                                db_cnt <= DB_ONE;
                                state  <= ST_RELEASE;
                            end
                        end
                    end

                    ST_RELEASE: begin
                        if (!cap_low) begin
                            if (db_cnt == DB_LAST) begin
                                db_cnt      <= '0;
                                state       <= ST_SCAN;
                                row_idx     <= row_idx + 2'd1;
                                key_pressed <= 1'b0;
                            end else begin
                                db_cnt <= db_cnt + DB_ONE;
                            end
                        end else begin
                            // Release bounced: key is still held, no new report.
                            db_cnt <= DB_MAX;
                            state  <= ST_HELD;
                        end
                    end

                    default: begin
                        db_cnt <= '0;
                        state  <= ST_SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
// Expected key codes are queued when a press is driven and popped when
// key_valid fires; levels and row strobes are checked directly.
`timescale 1ns/1ps
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    int         n_cmp;
    int         n_err;
    logic [3:0] exp_q[$];
    logic       prev_valid;
    logic [3:0] row_seq [4];

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .col         (col),
        .row         (row),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge right after row changes to tgt.
    task automatic wait_row(input logic [3:0] tgt);
        int n;
        n = 0;
        while (row === tgt && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (row !== tgt && n < 128) begin
            @(negedge clk);
            n++;
        end
        if (row !== tgt) chk("wait_row_timeout", row, tgt);
    endtask

    // Scoreboard: every key_valid must match the oldest queued press.
    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst && key_valid) begin
            chk("valid_width", prev_valid, 1'b0);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("code_at_valid", key_code, e);
                chk("pressed_at_valid", key_pressed, 1'b1);
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        prev_valid = 1'b0;
        row_seq[0] = 4'b1110;
        row_seq[1] = 4'b1101;
        row_seq[2] = 4'b1011;
        row_seq[3] = 4'b0111;
        rst = 1'b1;
        col = 4'b1111;

        // Reset state
        cycles(3);
        chk("rst_row", row, 4'b1110);
        chk("rst_code", key_code, 4'd0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_pressed", key_pressed, 1'b0);
        rst = 1'b0;

        // Idle scanning: row advances every 4 cycles
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            chk("idle_row", row, row_seq[(k / 4) % 4]);
        end
        chk("idle_pressed", key_pressed, 1'b0);

        // Clean press: column 2 on row 1 -> code 6
        wait_row(4'b1101);
        col = 4'b1011;
        exp_q.push_back(4'd6);
        cycles(11);
        chk("press_before_accept", key_pressed, 1'b0);
        cycles(5);
        chk("press_pressed", key_pressed, 1'b1);
        chk("press_code", key_code, 4'd6);
        chk("press_row_frozen", row, 4'b1101);
        chk("press_popped", exp_q.size(), 0);

        // Release glitch: 2 high ticks, then low again
        col = 4'b1111;
        cycles(8);
        chk("glitch_pressed_mid", key_pressed, 1'b1);
        col = 4'b1011;
        cycles(8);
        chk("glitch_pressed", key_pressed, 1'b1);
        chk("glitch_row", row, 4'b1101);

        // Real release: 3 high ticks
        col = 4'b1111;
        cycles(8);
        chk("release_pressed_2ticks", key_pressed, 1'b1);
        cycles(4);
        chk("release_pressed", key_pressed, 1'b0);
        chk("release_code_held", key_code, 4'd6);
        chk("release_row", row, 4'b1011);

        // Bounce: 2 low ticks then high -> no acceptance
        wait_row(4'b1101);
        col = 4'b1011;
        cycles(8);
        col = 4'b1111;
        cycles(4);
        chk("bounce_row", row, 4'b1011);
        chk("bounce_pressed", key_pressed, 1'b0);
        chk("bounce_code", key_code, 4'd6);

        // Two keys on row 0: lowest column wins -> code 1
        wait_row(4'b1110);
        col = 4'b1001;
        exp_q.push_back(4'd1);
        cycles(16);
        chk("two_code", key_code, 4'd1);
        chk("two_pressed", key_pressed, 1'b1);
        chk("two_row", row, 4'b1110);
        col = 4'b1111;
        cycles(16);
        chk("two_released", key_pressed, 1'b0);

        // Reset during debounce aborts the press
        wait_row(4'b1101);
        col = 4'b1011;
        cycles(8);
        rst = 1'b1;
        col = 4'b1111;
        cycles(1);
        chk("mid_rst_row", row, 4'b1110);
        chk("mid_rst_code", key_code, 4'd0);
        chk("mid_rst_pressed", key_pressed, 1'b0);
        chk("mid_rst_valid", key_valid, 1'b0);
        rst = 1'b0;
        cycles(1);
        chk("post_rst_row", row, 4'b1110);
        cycles(20);
        chk("post_rst_pressed", key_pressed, 1'b0);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per scan tick (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4, meaning consecutive agreeing ticks needed to accept a press or a release (minimum 1).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port col  input  4  keypad column lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port row  output  4  keypad row drive, active-low, one-hot-low.
REQ-007 SHALL have port key_code  output  4  code of last accepted key, row_idx*4+col_idx.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a press is accepted.
REQ-009 SHALL have port key_pressed  output  1  level, high from press acceptance until release acceptance.

Function
REQ-010 SHALL pass col through a two-flop synchronizer (col_s) before any use.
REQ-011 SHALL assert an internal tick for one cycle when the divider counter equals SCAN_DIV-1; the counter then wraps to 0 on the next cycle.
REQ-012 SHALL drive row = 4'b1111 - (1 << row_idx) at all times, where row_idx is a 2-bit register.
REQ-013 SHALL sample col_s only in tick cycles; no state change occurs in non-tick cycles except key_valid clearing.
REQ-014 SHALL implement the FSM states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-015 SCAN, tick, col_s == 4'b1111: row_idx increments mod 4 (3 wraps to 0).
REQ-016 SCAN, tick, any col_s bit low: capture row_idx and the lowest-numbered low column; set the debounce count to 1; row_idx freezes; go to DEBOUNCE, or go directly to HELD with acceptance if DEBOUNCE_CNT == 1.
REQ-017 DEBOUNCE, tick, captured column still low: increment the count; when the count reaches DEBOUNCE_CNT, go to HELD and accept the press.
REQ-018 DEBOUNCE, tick, captured column high: clear the count, return to SCAN, and increment row_idx.
REQ-019 Acceptance SHALL load key_code, set key_pressed, and pulse key_valid high for exactly one clk cycle, all in the cycle after the accepting tick.
REQ-020 HELD, tick, captured column high: set the count to 1 and go to RELEASE, or go directly to SCAN if DEBOUNCE_CNT == 1; otherwise stay in HELD.
REQ-021 RELEASE, tick, captured column high: increment the count; at DEBOUNCE_CNT, clear key_pressed, return to SCAN, and increment row_idx.
REQ-022 RELEASE, tick, captured column low: return to HELD with key_pressed still high and no new key_valid.
REQ-023 Additional keys pressed while in DEBOUNCE, HELD or RELEASE SHALL be ignored; only the captured row/column is tracked.
REQ-024 key_code SHALL hold its value until the next acceptance, including after release.
REQ-025 The debounce counter SHALL be ceil(log2(DEBOUNCE_CNT+1)) bits wide and SHALL never exceed DEBOUNCE_CNT.

Reset
REQ-026 On clk edge with rst high, the block SHALL set: divider counter 0, row_idx 0 (row = 4'b1110), state SCAN, debounce count 0, synchronizer flops 4'b1111, key_code 0, key_valid 0, key_pressed 0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort with no key_valid pulse; scanning SHALL restart from row 0 on the first cycle after rst falls.

Structure
REQ-028 FSM state encodings and the row/column widths (4) SHALL live in a shared package keypad_pkg.
REQ-029 The divider and tick generation SHALL be a sub-module keypad_tick_gen (parameter SCAN_DIV; ports clk, rst, tick).

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-030 Idle: col=4'b1111 for 40 cycles -> row sequence 1110,1101,1011,0111,1110 changing every 4 cycles; key_valid never high.
REQ-031 Clean press: hold col=4'b1011 (column 2) while row=4'b1101 (row 1) for 4 ticks -> key_valid single pulse, key_code=6, key_pressed=1, row frozen at 1101.
REQ-032 Bounce: column 2 low for 2 ticks then high -> no key_valid; scanning resumes with row=4'b1011.
REQ-033 Release glitch: from HELD, column high 2 ticks then low -> key_pressed stays 1, no second pulse; then 3 high ticks -> key_pressed=0.
REQ-034 Two keys: col=4'b1001 on row 0 -> key_code=1 (lowest column wins).
REQ-035 rst pulsed during DEBOUNCE -> all outputs at reset values, no key_valid, row=4'b1110 after reset.
